// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants and types for the button reader
package button_pkg;

  localparam int NUM_BTN = 4;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_HOLD    = 2'd2,
    EVT_RSVD    = 2'd3
  } evt_kind_e;

  typedef logic [1:0] chan_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one button channel: synchroniser, debounce, edge pulses
// Optional hold counter built when BUTTON_READER_HOLD_EN is defined.
module button_debounce #(
  parameter int DB_CYCLES   = 250000
`ifdef BUTTON_READER_HOLD_EN
  , parameter int HOLD_CYCLES = 25000000
`endif
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse
`ifdef BUTTON_READER_HOLD_EN
  , output logic hold
`endif
);

  localparam int              DB_W     = $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q, level_dly_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  always_comb begin
    sync_d  = {sync_q[0], btn};
    cnt_d   = '0;
    level_d = level_q;
    // Count only while the synchronised value disagrees; any agreement restarts it.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;
    release_d   = ~level_q & level_dly_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

`ifdef BUTTON_READER_HOLD_EN
  localparam int                HOLD_W    = $clog2(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_done_q, hold_done_d;
  logic              hold_q, hold_d;

  // hold_done blocks re-firing until the level drops and the channel is pressed again.
  always_comb begin
    hold_cnt_d  = '0;
    hold_done_d = 1'b0;
    hold_d      = 1'b0;
    if (level_q) begin
      hold_done_d = hold_done_q;
      if (!hold_done_q) begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_d      = 1'b1;
          hold_done_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt_q  <= '0;
      hold_done_q <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      hold_done_q <= hold_done_d;
      hold_q      <= hold_d;
    end
  end

  assign hold = hold_q;
`endif

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - four debounced buttons feeding a prioritised event register
// Hold events are built only when BUTTON_READER_HOLD_EN is defined.
module button_reader
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = 250000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] level,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_kind,
  output chan_t              evt_chan,
  output logic               evt_ovf
);

`ifdef BUTTON_READER_HOLD_EN
  localparam int NFLAG = 3 * NUM_BTN;
  logic [NUM_BTN-1:0] hold_pulse;
`else
  localparam int NFLAG = 2 * NUM_BTN;
`endif

  logic [NFLAG-1:0] pulse, avail, take;
  logic [NFLAG-1:0] pend_q, pend_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_kind_q, evt_kind_d;
  chan_t            evt_chan_q, evt_chan_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic             load, sel_hit;
  logic [3:0]       sel_idx;

  for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
    button_debounce #(
      .DB_CYCLES(DB_CYCLES)
`ifdef BUTTON_READER_HOLD_EN
      , .HOLD_CYCLES(HOLD_CYCLES)
`endif
    ) u_debounce (
      .clk           (clk),
      .resetn        (resetn),
      .btn           (btn[ch]),
      .level         (level[ch]),
      .press         (press[ch]),
      .release_pulse (release_pulse[ch])
`ifdef BUTTON_READER_HOLD_EN
      , .hold        (hold_pulse[ch])
`endif
    );
  end

  // Flag index = kind * NUM_BTN + channel, so the lowest set index is the highest priority.
`ifdef BUTTON_READER_HOLD_EN
  assign pulse = {hold_pulse, release_pulse, press};
`else
  assign pulse = {release_pulse, press};
`endif

  always_comb begin
    avail   = pend_q | pulse;
    load    = ~evt_valid_q | evt_ready;
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NFLAG - 1; i >= 0; i--) begin
      if (avail[i]) begin
        sel_hit = 1'b1;
        sel_idx = 4'(i);
      end
    end
    take = NFLAG'(load & sel_hit) << sel_idx;

    // A pulse landing on a flag that is being consumed this cycle re-arms it instead of overflowing.
    pend_d    = (avail & ~take) | (pend_q & pulse);
    evt_ovf_d = evt_ovf_q | (|(pend_q & pulse & ~take));

    evt_valid_d = evt_valid_q;
    evt_kind_d  = evt_kind_q;
    evt_chan_d  = evt_chan_q;
    if (load) begin
      evt_valid_d = sel_hit;
      if (sel_hit) begin
        evt_kind_d = sel_idx[3:2];
        evt_chan_d = sel_idx[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_kind_q  <= '0;
      evt_chan_q  <= '0;
      evt_ovf_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_kind_q  <= evt_kind_d;
      evt_chan_q  <= evt_chan_d;
      evt_ovf_q   <= evt_ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_kind  = evt_kind_q;
  assign evt_chan  = evt_chan_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - randomized scoreboard bench for button_reader
// Hold expectations follow BUTTON_READER_HOLD_EN.
module tb_button_reader;
  import button_pkg::*;

  localparam int DB   = 8;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] btn = '0;
  logic       evt_ready = 1'b0;
  logic [3:0] level, press, release_pulse;
  logic       evt_valid, evt_ovf;
  logic [1:0] evt_kind;
  logic [1:0] evt_chan;

  always #5 clk = ~clk;

  button_reader #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .btn           (btn),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_kind      (evt_kind),
    .evt_chan      (evt_chan),
    .evt_ovf       (evt_ovf)
  );

  int checks = 0;
  int errors = 0;
  int hold_seen = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as seen just after each rising edge.
  logic [3:0]  m_h1, m_h2, m_lvl;
  int          m_run[4];
  int          m_hcnt[4];
  logic        m_hdone[4];
  logic [11:0] m_pulse_now, m_pulse_next;
  int          m_pend[12];
  logic        m_valid, m_ovf;
  logic [1:0]  m_kind, m_chan;
  logic [3:0]  exp_q[$];

  task automatic model_reset();
    m_h1 = '0; m_h2 = '0; m_lvl = '0;
    m_pulse_now = '0; m_pulse_next = '0;
    m_valid = 1'b0; m_ovf = 1'b0; m_kind = '0; m_chan = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_hcnt[i] = 0; m_hdone[i] = 1'b0;
    end
    for (int i = 0; i < 12; i++) m_pend[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int taken;
    int c;
    logic s;
    taken = -1;
    if (!m_valid || evt_ready) begin
      for (int i = 0; i < 12; i++)
        if (taken < 0 && (m_pend[i] + int'(m_pulse_now[i])) > 0) taken = i;
      m_valid = (taken >= 0);
      if (taken >= 0) begin
        m_kind = 2'(taken / 4);
        m_chan = 2'(taken % 4);
        exp_q.push_back({m_kind, m_chan});
      end
    end
    for (int i = 0; i < 12; i++) begin
      c = m_pend[i] + int'(m_pulse_now[i]) - ((i == taken) ? 1 : 0);
      if (c > 1) begin
        m_ovf = 1'b1;
        c = 1;
      end
      m_pend[i] = c;
    end
    m_pulse_now  = m_pulse_next;
    m_pulse_next = '0;
    for (int ch = 0; ch < 4; ch++) begin
`ifdef BUTTON_READER_HOLD_EN
      if (m_lvl[ch]) begin
        if (!m_hdone[ch]) begin
          m_hcnt[ch]++;
          if (m_hcnt[ch] == HOLD) begin
            m_pulse_now[8 + ch] = 1'b1;
            m_hdone[ch] = 1'b1;
          end
        end
      end else begin
        m_hcnt[ch] = 0;
        m_hdone[ch] = 1'b0;
      end
`endif
      s = m_h2[ch];
      m_h2[ch] = m_h1[ch];
      m_h1[ch] = btn[ch];
      if (s != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DB) begin
          m_lvl[ch] = s;
          m_run[ch] = 0;
          m_pulse_next[(s ? 0 : 4) + ch] = 1'b1;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetn) model_reset();
      else         model_step();
    end
  end

  // Monitor: compares on the falling edge, pops the scoreboard on each handshake.
  initial begin
    logic       prev_stall;
    logic [3:0] prev_pl;
    logic [3:0] e;
    prev_stall = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("level", level, m_lvl);
        chk("press", press, m_pulse_now[3:0]);
        chk("release", release_pulse, m_pulse_now[7:4]);
        chk("evt_valid", evt_valid, m_valid);
        chk("evt_ovf", evt_ovf, m_ovf);
        if (prev_stall) begin
          chk("stall_valid", evt_valid, 1);
          chk("stall_payload", {evt_kind, evt_chan}, prev_pl);
        end
        if (evt_valid && evt_ready) begin
          hs_count++;
          if (evt_kind == 2'd2) hold_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d chan %0d, expected none", evt_kind, evt_chan);
          end else begin
            e = exp_q.pop_front();
            chk("event", {evt_kind, evt_chan}, e);
          end
        end
        prev_stall = evt_valid && !evt_ready;
        prev_pl = {evt_kind, evt_chan};
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rand_step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      evt_ready = ($urandom_range(3, 0) != 0);
    end
  endtask

  initial begin
    int lat;
    int hs_before;
    int b;
    step(3);
    chk("rst_level", level, 0);
    chk("rst_press", press, 0);
    chk("rst_release", release_pulse, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_kind", evt_kind, 0);
    chk("rst_chan", evt_chan, 0);
    chk("rst_ovf", evt_ovf, 0);
    resetn = 1'b1;
    step(2);

    // Clean rise on channel 1: latency of sync plus debounce
    lat = 0;
    btn[1] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (level[1]) begin
        lat = n;
        break;
      end
    end
    chk("t1_level_latency", lat, 10);
    evt_ready = 1'b1;
    step(5);
    btn[1] = 1'b0;
    step(20);

    // Short glitch on channel 0 is filtered
    btn[0] = 1'b1;
    step(5);
    btn[0] = 1'b0;
    step(20);
    chk("t2_glitch_level", level[0], 0);

    // Simultaneous presses held off by a stalled consumer
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    step(20);
    chk("t3_valid", evt_valid, 1);
    chk("t3_first_kind", evt_kind, EVT_PRESS);
    chk("t3_first_chan", evt_chan, 0);
    evt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_second_kind", evt_kind, EVT_PRESS);
    chk("t3_second_chan", evt_chan, 3);
    step(5);
    btn = '0;
    step(30);

    // Duplicate press on channel 2 while stalled overflows
    evt_ready = 1'b0;
    btn[1] = 1'b1;
    step(15);
    btn[2] = 1'b1;
    step(14);
    btn[2] = 1'b0;
    step(14);
    btn[2] = 1'b1;
    step(14);
    chk("t4_ovf_set", evt_ovf, 1);
    evt_ready = 1'b1;
    step(10);
    chk("t4_ovf_sticky", evt_ovf, 1);
    btn = '0;
    step(40);

    // Long hold on channel 2
    hold_seen = 0;
    btn[2] = 1'b1;
    step(80);
    btn[2] = 1'b0;
    step(30);
`ifdef BUTTON_READER_HOLD_EN
    chk("t5_hold_events", hold_seen, 1);
`else
    chk("t5_hold_events", hold_seen, 0);
`endif

    // Reset while an event is presented
    evt_ready = 1'b0;
    btn[0] = 1'b1;
    step(20);
    chk("t6_valid_before", evt_valid, 1);
    resetn = 1'b0;
    #1;
    chk("t6_level", level, 0);
    chk("t6_press", press, 0);
    chk("t6_release", release_pulse, 0);
    chk("t6_valid", evt_valid, 0);
    chk("t6_kind", evt_kind, 0);
    chk("t6_chan", evt_chan, 0);
    chk("t6_ovf", evt_ovf, 0);
    btn = '0;
    step(2);
    resetn = 1'b1;
    evt_ready = 1'b1;
    hs_before = hs_count;
    step(30);
    chk("t6_no_stale", hs_count - hs_before, 0);

    // Random toggles, glitches and back-pressure
    for (int k = 0; k < 300; k++) begin
      b = $urandom_range(3, 0);
      btn[b] = ~btn[b];
      rand_step($urandom_range(24, 1));
    end

    evt_ready = 1'b1;
    step(60);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_valid", evt_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side counterpart to the LED output path on the board top level: samples four raw push-button/switch pins, synchronises and debounces each one, and turns level changes into a queued event stream with a valid/ready handshake. It sits between the chip-level input pins and whatever pattern or control logic consumes user input, and runs in the single board clock domain.

## Interface
- DB_CYCLES, 250000: consecutive cycles a new sampled value must persist before it is accepted (10 ms at 25 MHz); must be ≥ 2.
- HOLD_CYCLES, 25000000: cycles a debounced level must stay high before a hold event fires; used only with the hold feature.
- clk  in  1  board clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- btn  in  4  raw button pins, active-high, asynchronous to clk.
- level  out  4  debounced button levels.
- press  out  4  one-cycle pulse per channel when its level goes 0→1.
- release  out  4  one-cycle pulse per channel when its level goes 1→0.
- evt_valid  out  1  event register holds an event.
- evt_ready  in  1  consumer accepts the event when it is high together with evt_valid.
- evt_kind  out  2  event kind: 0 press, 1 release, 2 hold, 3 reserved.
- evt_chan  out  2  channel index 0–3.
- evt_ovf  out  1  sticky: an event was lost; cleared only by reset.

## Operation
- Reset: level, press, release, evt_valid, evt_kind, evt_chan and evt_ovf are all 0. Synchronisers, counters and pending bits are cleared. Reset asserted mid-operation discards pending and presented events immediately.
- Per channel: two-flop synchroniser, then a debounce counter. The counter clears whenever the synchronised value equals level. When they differ, the counter increments. When it reaches DB_CYCLES-1 while still differing, level flips and the counter clears. Any glitch back to the current level restarts the count.
- press/release pulse on the cycle after level flips. Channels are independent, and several may pulse in the same cycle.
- Pending bits: eight flags (press and release per channel), plus four hold flags when hold is compiled in. Each pulse sets its flag.
- If a new pulse hits a flag that is already set, evt_ovf goes high and the duplicate is dropped.
- If a flag is set and cleared in the same cycle, the set wins.
- Event register selection: the register loads when it is empty, or when a handshake occurs this cycle. It takes the highest-priority pending flag and clears that flag.
- Priority order: press ch0..ch3, then release ch0..ch3, then hold ch0..ch3.
- While evt_valid is high without evt_ready, evt_kind and evt_chan remain stable.
- Widths: debounce counter is $clog2(DB_CYCLES) bits; hold counter is $clog2(HOLD_CYCLES) bits. Neither counter wraps, because both are cleared at the terminal value or on a level change.

## Timing
- Synchroniser latency is 2 cycles. A clean btn change is reflected on level after 2+DB_CYCLES rising edges.
- The press/release pulse follows level by 1 cycle. evt_valid rises 1 cycle after the pulse when the register is empty.
- Back-to-back throughput: with evt_ready held high, one event per cycle.
- The handshake and the reload happen on the same edge.
- When evt_valid=0, evt_ready is ignored.

## Configuration
- BUTTON_READER_HOLD_EN defined: each channel has a hold counter that runs while level is 1. At HOLD_CYCLES-1 it raises one hold pulse, which sets the hold pending flag. No further hold fires until the channel releases and presses again. The hold counter clears when level returns to 0.
- Not defined: no hold counters or hold flags are built, and evt_kind is never 2.

## Structure
- Shared package button_pkg holds:
  - the evt_kind constants EVT_PRESS=0, EVT_RELEASE=1, EVT_HOLD=2;
  - NUM_BTN=4;
  - the channel-index typedef.
- Sub-module button_debounce: one channel containing the synchroniser, debounce counter, level, press/release pulse, and the optional hold counter. It is instanced NUM_BTN times.
- The top of this block holds the pending flags, priority select, event register and overflow flag.

## Test plan
- DB_CYCLES=8, btn[1] 0→1 steady: level[1] rises after 10 edges, press[1] pulses once, then event kind 0 chan 1 is valid.
- A btn[0] high pulse lasting 5 cycles with DB_CYCLES=8: level, press and events stay 0 throughout.
- btn[0] and btn[3] rise together, evt_ready=0 for 20 cycles, then 1: events presented in order kind 0 chan 0, then kind 0 chan 3; payload is stable while stalled.
- Channel 2 toggled twice while evt_ready=0 with an earlier event stalled: the duplicate press is dropped, evt_ovf=1 and stays 1 until resetn.
- With BUTTON_READER_HOLD_EN, HOLD_CYCLES=16, btn[2] held: exactly one kind 2 chan 2 event after the press; none appear without the macro.
- resetn pulsed low while evt_valid=1: all outputs drop to 0 immediately, and no stale event appears after release.
